// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/acknowledge channel
// and the valid/ready channel toward the decoder.
interface instruction_fetch_if;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads at the current PC, queues returned
// instructions with their PC tag for the decoder, pulses pc_inc per accepted fetch.
//
// state   | meaning
// FETCH   | request presented at pc this cycle when the queue has room
// WAIT    | request outstanding, mem_addr held from the latched pc
// SETTLE  | idle cycle so the PC increment or branch reload becomes visible
// DISCARD | flushed while outstanding; response will be dropped
module instruction_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc,
    output logic        pc_inc,
    input  logic        flush,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_SETTLE,
        S_DISCARD
    } state_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [7:0]  addr_q;
    logic        issue;
    logic        push;
    logic        pop;
    logic [7:0]  push_pc;

    logic [31:0] q_data [DEPTH];
    logic [7:0]  q_tag  [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            addr_q <= 8'h00;
        end else begin
            state <= state_next;
            if (issue) begin
                addr_q <= pc;
            end
        end
    end

    // The request is raised in the FETCH cycle itself so a zero-wait memory can
    // answer immediately, giving one instruction every two cycles.
    always_comb begin
        state_next   = state;
        issue        = 1'b0;
        push         = 1'b0;
        push_pc      = addr_q;
        bus.mem_req  = 1'b0;
        bus.mem_addr = addr_q;
        case (state)
            S_FETCH: begin
                if (!reset && !flush && (count < FULL)) begin
                    issue        = 1'b1;
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = pc;
                    push_pc      = pc;
                    if (bus.mem_ack) begin
                        push       = 1'b1;
                        state_next = S_SETTLE;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    push       = !flush;
                    state_next = S_SETTLE;
                end else if (flush) begin
                    state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign pop             = bus.instr_valid & bus.instr_ready;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = q_data[rd_ptr];
    assign bus.instr_pc    = q_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            pc_inc <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= 32'h0000_0000;
                q_tag[i]  <= 8'h00;
            end
        end else begin
            pc_inc <= push;
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= rd_ptr;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= bus.mem_rdata;
                    q_tag[wr_ptr]  <= push_pc;
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: variable-latency memory model, PC register model,
// and a scoreboard of the PC sequence the decoder should receive.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  flush_pc = 8'h00;
    logic [7:0]  pc = 8'h00;
    logic        pc_inc;
    logic        ready = 1'b0;

    instruction_fetch_if bus ();

    instruction_fetch #(.DEPTH(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc     (pc),
        .pc_inc (pc_inc),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops = 0;

    // Program counter: reset to 0, branch reload on flush, else step on pc_inc.
    always @(posedge clk) begin
        if (reset)       pc <= 8'h00;
        else if (flush)  pc <= flush_pc;
        else if (pc_inc) pc <= pc + 8'd1;
    end

    // Memory model: latency fixed or random 0..3, optional hold, optional stray ack.
    int          lat_fixed = 0;
    bit          mem_hold = 1'b0;
    bit          inject_ack = 1'b0;
    bit          model_ack = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    bit          pending = 1'b0;
    int          left = 0;
    int          acks_seen = 0;

    assign bus.mem_ack     = model_ack | inject_ack;
    assign bus.mem_rdata   = model_rdata;
    assign bus.instr_ready = ready;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            model_ack = 1'b0;
            if (reset || !bus.mem_req) begin
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    pending = 1'b1;
                    left = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
                end
                if (left == 0 && !mem_hold) begin
                    model_ack   = 1'b1;
                    model_rdata = 32'hA000_0000 + {24'h0, bus.mem_addr};
                    pending     = 1'b0;
                    acks_seen++;
                end else if (left > 0) begin
                    left--;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected decoder stream: consecutive PCs from the last reset/branch target.
    int unsigned exp_q[$];

    task automatic set_base(input logic [7:0] b);
        exp_q.delete();
        for (int i = 0; i < 1500; i++) exp_q.push_back((int'(b) + i) % 256);
    endtask

    // Monitor: protocol checks and scoreboard pops, sampled mid-cycle.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_flush = 1'b0;
    logic        prev_reset = 1'b1;
    logic        prev_pc_inc = 1'b0;
    logic [7:0]  prev_addr = 8'h00;
    int unsigned e;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!prev_reset && prev_req && !prev_ack) begin
                    chk("req_hold", 32'(bus.mem_req), 32'd1);
                    chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
                end
                if (bus.mem_req && (!prev_req || prev_ack))
                    chk("req_addr_pc", 32'(bus.mem_addr), 32'(pc));
                if (prev_flush && !prev_reset)
                    chk("flush_empties", 32'(bus.instr_valid), 32'd0);
                if (pc_inc)
                    chk("pc_inc_width", 32'(prev_pc_inc), 32'd0);
                if (bus.instr_valid && bus.instr_ready && !flush) begin
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("instr_pc", 32'(bus.instr_pc), e);
                        chk("instr", bus.instr, 32'hA000_0000 + e);
                        pops++;
                    end
                end
            end
            prev_req    = bus.mem_req;
            prev_ack    = bus.mem_ack;
            prev_flush  = flush;
            prev_reset  = reset;
            prev_pc_inc = pc_inc;
            prev_addr   = bus.mem_addr;
        end
    end

    task automatic reset_values(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, bus.instr, 32'd0);
        chk({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'd0);
    endtask

    // Leaves the bench at the start of cycle 1 (first cycle with reset low).
    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b0;
        mem_hold = 1'b0;
        inject_ack = 1'b0;
        set_base(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic req_hist [1:12];
    logic [7:0] a6;
    int pulses;
    int acks0;

    initial begin
        // Zero-wait memory, decoder always ready.
        ready = 1'b1;
        lat_fixed = 0;
        apply_reset();
        pulses = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (pc_inc) pulses++;
            if (c == 1) chk("zw_first_req", 32'(bus.mem_req), 32'd1);
            if (c % 2 == 0) begin
                chk("zw_valid", 32'(bus.instr_valid), 32'd1);
                chk("zw_pc", 32'(bus.instr_pc), 32'(c / 2 - 1));
                chk("zw_pc_inc", 32'(pc_inc), 32'd1);
            end else begin
                chk("zw_gap_valid", 32'(bus.instr_valid), 32'd0);
            end
        end
        chk("zw_pulses", 32'(pulses), 32'd3);

        // Backpressure: queue fills at two entries, then one pop frees a slot.
        ready = 1'b0;
        apply_reset();
        acks0 = acks_seen;
        repeat (10) @(negedge clk);
        chk("bp_acks", 32'(acks_seen - acks0), 32'd2);
        chk("bp_req_low", 32'(bus.mem_req), 32'd0);
        chk("bp_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_head", 32'(bus.instr_pc), 32'd0);
        @(posedge clk); #1; ready = 1'b1;
        @(posedge clk); #1; ready = 1'b0;
        @(negedge clk);
        chk("bp_refetch_req", 32'(bus.mem_req), 32'd1);
        chk("bp_refetch_addr", 32'(bus.mem_addr), 32'd2);
        chk("bp_new_head", 32'(bus.instr_pc), 32'd1);

        // Three wait states: request held 4 cycles, fetch period 5.
        ready = 1'b1;
        lat_fixed = 3;
        apply_reset();
        a6 = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_hist[c] = bus.mem_req;
            if (c == 6) a6 = bus.mem_addr;
        end
        chk("ws_req_held", 32'(req_hist[1] & req_hist[2] & req_hist[3] & req_hist[4]), 32'd1);
        chk("ws_settle", 32'(req_hist[5]), 32'd0);
        chk("ws_next_req", 32'(req_hist[6]), 32'd1);
        chk("ws_next_addr", 32'(a6), 32'd1);
        chk("ws_third_gap", 32'(req_hist[10]), 32'd0);
        chk("ws_third_req", 32'(req_hist[11]), 32'd1);

        // Flush in WAIT with one queued entry; late ack is dropped.
        ready = 1'b0;
        lat_fixed = 0;
        apply_reset();
        @(posedge clk); #1; mem_hold = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_pc = 8'h40;
        flush = 1'b1;
        set_base(8'h40);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("fw_empty", 32'(bus.instr_valid), 32'd0);
        chk("fw_discard_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1; mem_hold = 1'b0;
        @(negedge clk);
        chk("fw_late_ack", 32'(bus.mem_ack), 32'd1);
        @(negedge clk);
        chk("fw_no_pc_inc", 32'(pc_inc), 32'd0);
        chk("fw_still_empty", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk("fw_new_req", 32'(bus.mem_req), 32'd1);
        chk("fw_new_addr", 32'(bus.mem_addr), 32'h40);
        ready = 1'b1;
        repeat (6) @(negedge clk);

        // Flush coincident with ack and a ready decoder.
        ready = 1'b0;
        lat_fixed = 1;
        apply_reset();
        repeat (4) begin @(posedge clk); #1; end
        flush_pc = 8'h80;
        flush = 1'b1;
        ready = 1'b1;
        set_base(8'h80);
        @(negedge clk);
        chk("fc_ack", 32'(bus.mem_ack), 32'd1);
        chk("fc_valid_before", 32'(bus.instr_valid), 32'd1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("fc_empty", 32'(bus.instr_valid), 32'd0);
        chk("fc_no_pc_inc", 32'(pc_inc), 32'd0);
        @(negedge clk);
        chk("fc_no_pc_inc2", 32'(pc_inc), 32'd0);
        chk("fc_new_req", 32'(bus.mem_req), 32'd1);
        chk("fc_new_addr", 32'(bus.mem_addr), 32'h80);
        repeat (6) @(negedge clk);

        // Reset during WAIT with a queued entry; stale acks while in reset.
        ready = 1'b0;
        lat_fixed = 0;
        apply_reset();
        @(posedge clk); #1; mem_hold = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        set_base(8'h00);
        @(negedge clk);
        chk("rw_in_wait", 32'(bus.instr_valid), 32'd1);
        @(posedge clk); #1; mem_hold = 1'b0; inject_ack = 1'b1;
        @(negedge clk);
        reset_values("rw");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_stale_valid", 32'(bus.instr_valid), 32'd0);
        chk("rw_stale_pc_inc", 32'(pc_inc), 32'd0);
        @(posedge clk); #1; inject_ack = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rw_after_valid", 32'(bus.instr_valid), 32'd0);
        chk("rw_after_pc_inc", 32'(pc_inc), 32'd0);

        // Randomized run: random latency, backpressure and branches.
        lat_fixed = -1;
        apply_reset();
        pops = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            ready = ($urandom_range(0, 3) != 0);
            if (flush) begin
                flush = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                flush_pc = 8'($urandom);
                flush = 1'b1;
                set_base(flush_pc);
            end
        end
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("rand_progress", 32'(pops > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
